// File: rtl/capture_pkg.sv
// ============================================================================
// Module      : capture_pkg
// Description : Shared FSM state encoding and default frame geometry for the
//               trigger capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_pkg;

  // Default geometry follows the 16-bit XADC sample path of the filter chain.
  localparam int CAP_DATA_SIZE = 16;
  localparam int CAP_DEPTH     = 256;
  localparam int CAP_ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // True for the states in which incoming samples are stored.
  function automatic logic is_capturing(input state_t st);
    return (st == ST_PRE) || (st == ST_WAIT_TRIG) || (st == ST_POST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/capture_ram.sv
// ============================================================================
// Module      : capture_ram
// Description : Simple dual-port frame buffer; one write port, one read port
//               with a registered output (BRAM-inferable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_ram #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  input  logic [ADDR_SIZE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0] rd_data_o
);

  localparam int RAM_WORDS = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [RAM_WORDS];
  logic [DATA_SIZE-1:0] rd_data_q;

  // Write port; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; only the output register is cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/trigger_capture.sv
// ============================================================================
// Module      : trigger_capture
// Description : Level/edge triggered frame capture with programmable
//               pre-trigger depth, force trigger and logical read-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_capture
  import capture_pkg::*;
#(
  parameter int DATA_SIZE = CAP_DATA_SIZE,
  parameter int DEPTH     = CAP_DEPTH,
  parameter int ADDR_SIZE = CAP_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] sample,
  input  logic                 arm,
  input  logic                 force_trig,   // pulse; trigger without a level crossing
  input  logic [DATA_SIZE-1:0] trig_level,
  input  logic                 trig_edge,
  input  logic [ADDR_SIZE-1:0] pretrig,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 busy,
  output logic                 triggered,
  output logic                 frame_ready
);

  // Samples following the trigger when pretrig is zero (DEPTH-1).
  localparam logic [ADDR_SIZE-1:0] c_post_max = ADDR_SIZE'(DEPTH - 1);

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] level_q, level_d;
  logic                 edge_q, edge_d;
  logic [ADDR_SIZE-1:0] pretrig_q, pretrig_d;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] start_q, start_d;
  logic [ADDR_SIZE-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_SIZE-1:0] post_cnt_q, post_cnt_d;
  logic [DATA_SIZE-1:0] prev_q, prev_d;
  logic                 prev_valid_q, prev_valid_d;
  logic                 force_pending_q, force_pending_d;
  logic                 triggered_q, triggered_d;
  logic                 busy_q;
  logic                 frame_ready_q;

  logic                 w_accept;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_trig;
  logic [ADDR_SIZE-1:0] w_pre_next;
  logic [ADDR_SIZE-1:0] w_post_len;
  logic [ADDR_SIZE-1:0] w_rd_phys;

  // Arm has priority over an incoming sample on the same cycle.
  assign w_accept   = sample_valid && !arm && is_capturing(state_q);
  assign w_rise     = (prev_q < level_q) && (sample >= level_q);
  assign w_fall     = (prev_q > level_q) && (sample <= level_q);
  assign w_trig     = w_accept && (state_q == ST_WAIT_TRIG) &&
                      (force_pending_q || (prev_valid_q && (edge_q ? w_fall : w_rise)));
  assign w_pre_next = pre_cnt_q + 1'b1;
  assign w_post_len = c_post_max - pretrig_q;
  assign w_rd_phys  = start_q + rd_addr;

  // Next-state computation for the capture FSM and its datapath registers.
  always_comb begin
    state_d         = state_q;
    level_d         = level_q;
    edge_d          = edge_q;
    pretrig_d       = pretrig_q;
    wr_ptr_d        = wr_ptr_q;
    start_d         = start_q;
    pre_cnt_d       = pre_cnt_q;
    post_cnt_d      = post_cnt_q;
    prev_d          = prev_q;
    prev_valid_d    = prev_valid_q;
    force_pending_d = force_pending_q;
    triggered_d     = triggered_q;

    if (arm) begin
      level_d         = trig_level;
      edge_d          = trig_edge;
      pretrig_d       = pretrig;
      pre_cnt_d       = '0;
      prev_valid_d    = 1'b0;
      force_pending_d = 1'b0;
      triggered_d     = 1'b0;
      state_d         = (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
    end else begin
      if (force_trig && ((state_q == ST_PRE) || (state_q == ST_WAIT_TRIG))) begin
        force_pending_d = 1'b1;
      end
      if (w_accept) begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        prev_d       = sample;
        prev_valid_d = 1'b1;
        case (state_q)
          ST_PRE: begin
            pre_cnt_d = w_pre_next;
            if (w_pre_next == pretrig_q) begin
              state_d = ST_WAIT_TRIG;
            end
          end
          ST_WAIT_TRIG: begin
            if (w_trig) begin
              // Frame starts pretrig slots behind the trigger sample's slot.
              start_d         = wr_ptr_q - pretrig_q;
              triggered_d     = 1'b1;
              force_pending_d = 1'b0;
              post_cnt_d      = w_post_len;
              state_d         = (w_post_len == '0) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == {{(ADDR_SIZE-1){1'b0}}, 1'b1}) begin
              state_d = ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and datapath registers; status outputs are registered from next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      level_q         <= '0;
      edge_q          <= 1'b0;
      pretrig_q       <= '0;
      wr_ptr_q        <= '0;
      start_q         <= '0;
      pre_cnt_q       <= '0;
      post_cnt_q      <= '0;
      prev_q          <= '0;
      prev_valid_q    <= 1'b0;
      force_pending_q <= 1'b0;
      triggered_q     <= 1'b0;
      busy_q          <= 1'b0;
      frame_ready_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      edge_q          <= edge_d;
      pretrig_q       <= pretrig_d;
      wr_ptr_q        <= wr_ptr_d;
      start_q         <= start_d;
      pre_cnt_q       <= pre_cnt_d;
      post_cnt_q      <= post_cnt_d;
      prev_q          <= prev_d;
      prev_valid_q    <= prev_valid_d;
      force_pending_q <= force_pending_d;
      triggered_q     <= triggered_d;
      busy_q          <= is_capturing(state_d);
      frame_ready_q   <= (state_d == ST_DONE);
    end
  end

  capture_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample),
    .rd_addr_i (w_rd_phys),
    .rd_data_o (rd_data)
  );

  assign busy        = busy_q;
  assign triggered   = triggered_q;
  assign frame_ready = frame_ready_q;

endmodule

`default_nettype wire
